// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel-timing stage: default 640x480@60 timing,
// the TinyVGA Pmod bit positions and the helper that assembles the Pmod byte.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  localparam int unsigned POS_W = 10;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [POS_W:0]   pos_ext_t;
  typedef logic [5:0]       rgb_t;
  typedef logic [7:0]       pmod_t;

  // TinyVGA Pmod byte layout {HS,B0,G0,R0,VS,B1,G1,R1}
  localparam int unsigned PMOD_HS = 7;
  localparam int unsigned PMOD_B0 = 6;
  localparam int unsigned PMOD_G0 = 5;
  localparam int unsigned PMOD_R0 = 4;
  localparam int unsigned PMOD_VS = 3;
  localparam int unsigned PMOD_B1 = 2;
  localparam int unsigned PMOD_G1 = 1;
  localparam int unsigned PMOD_R1 = 0;

  // Colour input is {R1,R0,G1,G0,B1,B0}; sync arguments are pin levels.
  function automatic pmod_t pmod_pack(input logic hs, input logic vs, input rgb_t c);
    pmod_t b;
    b          = '0;
    b[PMOD_HS] = hs;
    b[PMOD_VS] = vs;
    b[PMOD_R1] = c[5];
    b[PMOD_R0] = c[4];
    b[PMOD_G1] = c[3];
    b[PMOD_G0] = c[2];
    b[PMOD_B1] = c[1];
    b[PMOD_B0] = c[0];
    return b;
  endfunction

endpackage

// File: rtl/vga_out_pack.sv
// Output packer: gates colour outside the visible area, applies sync polarity
// and registers the Pmod byte. Holds while enable is low.
module vga_out_pack
  import vga_pkg::*;
#(
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_hsync_act,
  input  logic       i_vsync_act,
  input  logic       i_display_on,
  input  logic [5:0] i_rgb,
  output logic [7:0] o_vga_out
);

  localparam pmod_t RESET_BYTE = pmod_pack(SYNC_NEG, SYNC_NEG, '0);

  rgb_t  w_rgb_gated;
  logic  w_hs_pin;
  logic  w_vs_pin;
  pmod_t r_vga_out;

  // Colour gating and sync pin levels for the current counter state
  always_comb begin
    w_rgb_gated = i_display_on ? i_rgb : '0;
    w_hs_pin    = i_hsync_act ^ SYNC_NEG;
    w_vs_pin    = i_vsync_act ^ SYNC_NEG;
  end

  // Pmod byte register; reset drives inactive sync and black
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vga_out <= RESET_BYTE;
    end else if (i_en) begin
      r_vga_out <= pmod_pack(w_hs_pin, w_vs_pin, w_rgb_gated);
    end
  end

  assign o_vga_out = r_vga_out;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing stage: raster counters, sync/blanking decode, line/frame
// strobes, completed-frame counter and the registered Pmod output byte.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter bit          SYNC_NEG = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] rgb,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt,
  output logic [7:0] vga_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam pos_t     H_LAST   = pos_t'(H_TOTAL - 1);
  localparam pos_t     V_LAST   = pos_t'(V_TOTAL - 1);
  // Window bounds carry one extra bit so an end bound of 1024 stays exact
  localparam pos_ext_t H_ACT_E  = pos_ext_t'(H_ACTIVE);
  localparam pos_ext_t V_ACT_E  = pos_ext_t'(V_ACTIVE);
  localparam pos_ext_t HS_BEG_E = pos_ext_t'(H_ACTIVE + H_FRONT);
  localparam pos_ext_t HS_END_E = pos_ext_t'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam pos_ext_t VS_BEG_E = pos_ext_t'(V_ACTIVE + V_FRONT);
  localparam pos_ext_t VS_END_E = pos_ext_t'(V_ACTIVE + V_FRONT + V_SYNC);

  pos_t        r_hpos;
  pos_t        r_vpos;
  logic [7:0]  r_frame_cnt;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_display_on;
  logic        w_hsync_act;
  logic        w_vsync_act;
  pos_ext_t    w_hpos_e;
  pos_ext_t    w_vpos_e;

  // Wrap detection and window decode from the counter registers
  always_comb begin
    w_hpos_e     = {1'b0, r_hpos};
    w_vpos_e     = {1'b0, r_vpos};
    w_h_wrap     = (r_hpos == H_LAST);
    w_v_wrap     = (r_vpos == V_LAST);
    w_display_on = (w_hpos_e < H_ACT_E) && (w_vpos_e < V_ACT_E);
    w_hsync_act  = (w_hpos_e >= HS_BEG_E) && (w_hpos_e < HS_END_E);
    w_vsync_act  = (w_vpos_e >= VS_BEG_E) && (w_vpos_e < VS_END_E);
  end

  // Raster counters and completed-frame counter, advancing on enable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hpos      <= '0;
      r_vpos      <= '0;
      r_frame_cnt <= '0;
    end else if (en) begin
      if (w_h_wrap) begin
        r_hpos <= '0;
        if (w_v_wrap) begin
          r_vpos      <= '0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_vpos <= r_vpos + 10'd1;
        end
      end else begin
        r_hpos <= r_hpos + 10'd1;
      end
    end
  end

  // Strobes are suppressed while reset is held
  always_comb begin
    line_start  = !rst && (r_hpos == '0);
    frame_start = !rst && (r_hpos == '0) && (r_vpos == '0);
  end

  assign hpos       = r_hpos;
  assign vpos       = r_vpos;
  assign display_on = w_display_on;
  assign frame_cnt  = r_frame_cnt;

  vga_out_pack #(
    .SYNC_NEG (SYNC_NEG)
  ) u_pack (
    .clk          (clk),
    .rst          (rst),
    .i_en         (en),
    .i_hsync_act  (w_hsync_act),
    .i_vsync_act  (w_vsync_act),
    .i_display_on (w_display_on),
    .i_rgb        (rgb),
    .o_vga_out    (vga_out)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing instance plus a
// small-raster instance (H 8/2/2/2, V 4/1/1/1) for frame-level behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-timing instance
  logic       d_rst, d_en;
  logic [5:0] d_rgb;
  logic [9:0] d_hpos, d_vpos;
  logic       d_display_on, d_line_start, d_frame_start;
  logic [7:0] d_frame_cnt, d_vga_out;

  // Small-raster instance: H_TOTAL 14, V_TOTAL 7, 98 pixels per frame
  logic       s_rst, s_en;
  logic [5:0] s_rgb;
  logic [9:0] s_hpos, s_vpos;
  logic       s_display_on, s_line_start, s_frame_start;
  logic [7:0] s_frame_cnt, s_vga_out;

  vga_timing_gen u_def (
    .clk         (clk),
    .rst         (d_rst),
    .en          (d_en),
    .rgb         (d_rgb),
    .hpos        (d_hpos),
    .vpos        (d_vpos),
    .display_on  (d_display_on),
    .line_start  (d_line_start),
    .frame_start (d_frame_start),
    .frame_cnt   (d_frame_cnt),
    .vga_out     (d_vga_out)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FRONT  (2),
    .H_SYNC   (2),
    .H_BACK   (2),
    .V_ACTIVE (4),
    .V_FRONT  (1),
    .V_SYNC   (1),
    .V_BACK   (1),
    .SYNC_NEG (1'b1)
  ) u_small (
    .clk         (clk),
    .rst         (s_rst),
    .en          (s_en),
    .rgb         (s_rgb),
    .hpos        (s_hpos),
    .vpos        (s_vpos),
    .display_on  (s_display_on),
    .line_start  (s_line_start),
    .frame_start (s_frame_start),
    .frame_cnt   (s_frame_cnt),
    .vga_out     (s_vga_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int found;
    int lows;
    int first;
    int exp_h;
    int exp_v;
    int mism;

    d_rst = 1'b1; d_en = 1'b1; d_rgb = 6'h3F;
    s_rst = 1'b1; s_en = 1'b1; s_rgb = 6'h00;

    // Reset held for 5 cycles
    repeat (5) tick();
    chk("rst_vga",   d_vga_out, 8'h88);
    chk("rst_hpos",  d_hpos, 0);
    chk("rst_vpos",  d_vpos, 0);
    chk("rst_fcnt",  d_frame_cnt, 0);
    chk("rst_ls",    d_line_start, 0);
    chk("rst_fs",    d_frame_start, 0);
    chk("rst_disp",  d_display_on, 1);
    chk("rst_s_vga", s_vga_out, 8'h88);

    // First cycle after release
    d_rst = 1'b0;
    #1;
    chk("fs_first", d_frame_start, 1);
    chk("ls_first", d_line_start, 1);
    tick();
    chk("fs_once",  d_frame_start, 0);
    chk("hpos_one", d_hpos, 1);

    // Align to the next line start
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      tick();
      if (d_line_start) found = 1;
    end
    chk("ls_found", found, 1);
    chk("ls_vpos",  d_vpos, 1);

    // Two lines of hsync width / position and blanking byte values
    for (int line = 0; line < 2; line++) begin
      lows  = 0;
      first = 0;
      for (int k = 1; k <= 800; k++) begin
        tick();
        if (!d_vga_out[7]) begin
          lows++;
          if (first == 0) first = k;
        end
        if (line == 0) begin
          case (k)
            1:   chk("pix_first",  d_vga_out, 8'hFF);
            640: chk("pix_last",   d_vga_out, 8'hFF);
            641: chk("fp_first",   d_vga_out, 8'h88);
            656: chk("fp_last",    d_vga_out, 8'h88);
            657: chk("hs_first",   d_vga_out, 8'h08);
            752: chk("hs_last",    d_vga_out, 8'h08);
            753: chk("bp_first",   d_vga_out, 8'h88);
            default: ;
          endcase
        end
      end
      chk("hs_width", lows, 96);
      chk("hs_fall",  first, 657);
    end

    // Mid-line reset inside hsync
    repeat (700) tick();
    chk("pre_hpos", d_hpos, 700);
    chk("pre_vpos", d_vpos, 3);
    chk("pre_vga",  d_vga_out, 8'h08);
    d_rst = 1'b1;
    tick();
    chk("mrst_vga",  d_vga_out, 8'h88);
    chk("mrst_hpos", d_hpos, 0);
    chk("mrst_vpos", d_vpos, 0);
    chk("mrst_fs",   d_frame_start, 0);
    d_rst = 1'b0;

    // Small raster: vsync width and position over one frame
    s_rst = 1'b0;
    #1;
    chk("s_fs_first", s_frame_start, 1);
    lows  = 0;
    first = 0;
    for (int k = 1; k <= 98; k++) begin
      tick();
      if (!s_vga_out[3]) begin
        lows++;
        if (first == 0) first = k;
      end
    end
    chk("vs_width", lows, 14);
    chk("vs_fall",  first, 71);
    chk("s_fcnt1",  s_frame_cnt, 1);
    chk("s_hpos0",  s_hpos, 0);

    // Enable toggling 1-on/1-off for 3 frames against a counter model
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    exp_h = 0;
    exp_v = 0;
    mism  = 0;
    for (int i = 0; i < 588; i++) begin
      s_en = ((i % 2) == 0);
      tick();
      if (s_en) begin
        if (exp_h == 13) begin
          exp_h = 0;
          exp_v = (exp_v == 6) ? 0 : exp_v + 1;
        end else begin
          exp_h++;
        end
      end
      if (s_hpos !== exp_h[9:0] || s_vpos !== exp_v[9:0]) mism++;
    end
    s_en = 1'b1;
    chk("en_track", mism, 0);
    chk("en_fcnt3", s_frame_cnt, 3);
    chk("en_hpos",  s_hpos, 0);

    // frame_cnt wraps after 256 frames
    repeat (253 * 98) tick();
    chk("fcnt_wrap", s_frame_cnt, 0);
    chk("wrap_vpos", s_vpos, 0);

    // Mid-frame reset inside both sync windows
    repeat (98 + 81) tick();
    chk("s_pre_hpos", s_hpos, 11);
    chk("s_pre_vpos", s_vpos, 5);
    chk("s_pre_vga",  s_vga_out, 8'h00);
    chk("s_pre_fcnt", s_frame_cnt, 1);
    s_rst = 1'b1;
    tick();
    chk("s_mrst_vga",  s_vga_out, 8'h88);
    chk("s_mrst_hpos", s_hpos, 0);
    chk("s_mrst_vpos", s_vpos, 0);
    chk("s_mrst_fcnt", s_frame_cnt, 0);
    s_rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
